// File: rtl/pc_unit_if.sv
// Bus bundle between the PC unit and fetch/branch control.
// The master drives the next-PC selection; the slave (pc_unit) returns the PC values.
interface pc_unit_if #(
  parameter int XLEN = 32
);
  logic            en;
  logic [1:0]      pc_sel;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] pc_tmp;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_add4;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] pc_next;
  logic            misalign;

  modport master (
    output en, pc_sel, imm, rs1, pc_tmp,
    input  pc, pc_add4, pc_imm, pc_next, misalign
  );

  modport slave (
    input  en, pc_sel, imm, rs1, pc_tmp,
    output pc, pc_add4, pc_imm, pc_next, misalign
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with pc+4 / pc+imm adders and next-PC selection.
// Define PC_MISALIGN_CHECK_EN to flag misaligned targets and block the update on them.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input logic        clk,
  input logic        rst,
  pc_unit_if.slave   bus
);
  localparam logic [XLEN-1:0] LSB_CLEAR = ~{{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] FOUR      = {{(XLEN-3){1'b0}}, 3'b100};

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] add4;
  logic [XLEN-1:0] add_imm;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] nxt;
  logic            mis;
  logic            load;

  assign add4     = pc_q + FOUR;
  assign add_imm  = pc_q + bus.imm;
  assign jalr_tgt = (bus.rs1 + bus.imm) & LSB_CLEAR;

  always_comb begin
    nxt = add4;
    case (bus.pc_sel)
      2'd0:    nxt = add4;
      2'd1:    nxt = add_imm;
      2'd2:    nxt = jalr_tgt;
      default: nxt = bus.pc_tmp;
    endcase
  end

`ifdef PC_MISALIGN_CHECK_EN
  // Held PC on a misaligned target lets trap logic redirect through pc_tmp later.
  assign mis  = rst & bus.en & (nxt[1:0] != 2'b00);
  assign load = bus.en & ~mis;
`else
  assign mis  = 1'b0;
  assign load = bus.en;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_VECTOR;
    end else if (load) begin
      pc_q <= nxt;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_add4  = add4;
  assign bus.pc_imm   = add_imm;
  assign bus.pc_next  = nxt;
  assign bus.misalign = mis;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// compared against a behavioural PC model.
module tb_pc_unit;
  localparam int              XLEN = 32;
  localparam logic [XLEN-1:0] RV   = 32'h0000_0000;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [XLEN-1:0] model_pc;

  pc_unit_if #(.XLEN(XLEN)) bus ();

  pc_unit #(.XLEN(XLEN), .RESET_VECTOR(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  function automatic logic [XLEN-1:0] model_next(input logic [1:0] sel,
                                                 input logic [XLEN-1:0] pc,
                                                 input logic [XLEN-1:0] imm,
                                                 input logic [XLEN-1:0] rs1,
                                                 input logic [XLEN-1:0] tmp);
    logic [XLEN-1:0] t;
    case (sel)
      2'd0:    t = pc + 32'd4;
      2'd1:    t = pc + imm;
      2'd2:    t = ((rs1 + imm) / 2) * 2;
      default: t = tmp;
    endcase
    return t;
  endfunction

  function automatic logic model_mis(input logic [XLEN-1:0] nxt, input logic en);
`ifdef PC_MISALIGN_CHECK_EN
    return en && (nxt % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive(input logic en, input logic [1:0] sel, input logic [XLEN-1:0] imm,
                       input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] tmp);
    bus.en     = en;
    bus.pc_sel = sel;
    bus.imm    = imm;
    bus.rs1    = rs1;
    bus.pc_tmp = tmp;
  endtask

  // Advance the model for the coming edge, then wait past that edge.
  task automatic tick();
    logic [XLEN-1:0] n;
    n = model_next(bus.pc_sel, model_pc, bus.imm, bus.rs1, bus.pc_tmp);
    if (rst && bus.en && !model_mis(n, bus.en)) model_pc = n;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'd0, 32'd8, '0, '0);
    #2 rst = 1'b0;
    #1;
    model_pc = RV;
    vectors++;
    if (bus.pc !== RV) begin
      miscompares++;
      $display("FAIL reset_async: pc=%h expected %h", bus.pc, RV);
    end
    vectors++;
    if (bus.misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_misalign: misalign=%b expected 0", bus.misalign);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.pc !== RV) begin
      miscompares++;
      $display("FAIL reset_hold: pc=%h expected %h", bus.pc, RV);
    end
    #2 rst = 1'b1;
  endtask

  task automatic test_increment();
    logic [XLEN-1:0] exp;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp = 32'(4 * i);
      vectors++;
      if (bus.pc !== exp) begin
        miscompares++;
        $display("FAIL incr_pc[%0d]: pc=%h expected %h", i, bus.pc, exp);
      end
      vectors++;
      if (bus.pc_imm !== exp + 32'd8) begin
        miscompares++;
        $display("FAIL incr_pc_imm[%0d]: pc_imm=%h expected %h", i, bus.pc_imm, exp + 32'd8);
      end
    end
  endtask

  task automatic test_async_reset();
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (bus.pc !== RV) begin
      miscompares++;
      $display("FAIL async_reset_drop: pc=%h expected %h", bus.pc, RV);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.pc !== RV) begin
      miscompares++;
      $display("FAIL async_reset_edge: pc=%h expected %h", bus.pc, RV);
    end
    #1 rst = 1'b1;
    model_pc = RV;
    for (int i = 1; i <= 2; i++) begin
      tick();
      vectors++;
      if (bus.pc !== 32'(4 * i)) begin
        miscompares++;
        $display("FAIL async_reset_restart[%0d]: pc=%h expected %h", i, bus.pc, 32'(4 * i));
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 2'd3, '0, '0, 32'h20);
    tick();
    drive(1'b0, 2'd0, 32'd8, '0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.pc !== 32'h20 || bus.pc_add4 !== 32'h24) begin
        miscompares++;
        $display("FAIL hold[%0d]: pc=%h pc_add4=%h expected 00000020/00000024", i, bus.pc, bus.pc_add4);
      end
      vectors++;
      if (bus.misalign !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_misalign[%0d]: misalign=%b expected 0", i, bus.misalign);
      end
    end
  endtask

  task automatic test_branch_jalr_tmp();
    logic [XLEN-1:0] exp;
    drive(1'b1, 2'd3, '0, '0, 32'h100);
    tick();
    drive(1'b1, 2'd1, 32'hFFFF_FFF0, '0, '0);
    #1;
    vectors++;
    if (bus.pc_imm !== 32'hF0 || bus.pc_next !== 32'hF0) begin
      miscompares++;
      $display("FAIL branch_comb: pc_imm=%h pc_next=%h expected 000000f0", bus.pc_imm, bus.pc_next);
    end
    tick();
    vectors++;
    if (bus.pc !== 32'hF0) begin
      miscompares++;
      $display("FAIL branch_pc: pc=%h expected 000000f0", bus.pc);
    end
    drive(1'b1, 2'd2, '0, 32'h203, '0);
    #1;
    vectors++;
    if (bus.pc_next !== 32'h202) begin
      miscompares++;
      $display("FAIL jalr_next: pc_next=%h expected 00000202", bus.pc_next);
    end
    tick();
`ifdef PC_MISALIGN_CHECK_EN
    exp = 32'hF0;
`else
    exp = 32'h202;
`endif
    vectors++;
    if (bus.pc !== exp) begin
      miscompares++;
      $display("FAIL jalr_pc: pc=%h expected %h", bus.pc, exp);
    end
    drive(1'b1, 2'd3, '0, '0, 32'h8000_0000);
    tick();
    vectors++;
    if (bus.pc !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL tmp_pc: pc=%h expected 80000000", bus.pc);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 2'd3, '0, '0, 32'hFFFF_FFFC);
    tick();
    drive(1'b1, 2'd0, '0, '0, '0);
    #1;
    vectors++;
    if (bus.pc_add4 !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_add4: pc_add4=%h expected 00000000", bus.pc_add4);
    end
    tick();
    vectors++;
    if (bus.pc !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_pc: pc=%h expected 00000000", bus.pc);
    end
  endtask

  task automatic test_misalign();
    logic            exp_mis;
    logic [XLEN-1:0] exp_pc;
`ifdef PC_MISALIGN_CHECK_EN
    exp_mis = 1'b1;
    exp_pc  = 32'h10;
`else
    exp_mis = 1'b0;
    exp_pc  = 32'h12;
`endif
    drive(1'b1, 2'd3, '0, '0, 32'h10);
    tick();
    drive(1'b1, 2'd1, 32'd2, '0, '0);
    #1;
    vectors++;
    if (bus.misalign !== exp_mis) begin
      miscompares++;
      $display("FAIL misalign_flag: misalign=%b expected %b", bus.misalign, exp_mis);
    end
    tick();
    vectors++;
    if (bus.pc !== exp_pc) begin
      miscompares++;
      $display("FAIL misalign_pc: pc=%h expected %h", bus.pc, exp_pc);
    end
    bus.en = 1'b0;
    #1;
    vectors++;
    if (bus.misalign !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_en0: misalign=%b expected 0", bus.misalign);
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] exp_next;
    logic            exp_mis;
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
      #1;
      exp_next = model_next(bus.pc_sel, model_pc, bus.imm, bus.rs1, bus.pc_tmp);
      exp_mis  = model_mis(exp_next, bus.en);
      vectors++;
      if (bus.pc_add4 !== model_pc + 32'd4 || bus.pc_imm !== model_pc + bus.imm) begin
        miscompares++;
        $display("FAIL rand_adders[%0d]: pc_add4=%h pc_imm=%h expected %h/%h",
                 i, bus.pc_add4, bus.pc_imm, model_pc + 32'd4, model_pc + bus.imm);
      end
      vectors++;
      if (bus.pc_next !== exp_next || bus.misalign !== exp_mis) begin
        miscompares++;
        $display("FAIL rand_next[%0d]: pc_next=%h misalign=%b expected %h/%b",
                 i, bus.pc_next, bus.misalign, exp_next, exp_mis);
      end
      tick();
      vectors++;
      if (bus.pc !== model_pc) begin
        miscompares++;
        $display("FAIL rand_pc[%0d]: pc=%h expected %h", i, bus.pc, model_pc);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_pc    = RV;
    test_reset();
    test_increment();
    test_async_reset();
    test_hold();
    test_branch_jalr_tmp();
    test_wrap();
    test_misalign();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
